// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;

  modport master (output tx_data, output tx_valid,
                  input tx_ready, input tx_done, input tx_err);
  modport slave  (input tx_data, input tx_valid,
                  output tx_ready, output tx_done, output tx_err);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ACK check).
// Optional watchdog on the device-clocked phases: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx (
  input  logic         clk25,
  input  logic         clr,
  ps2_host_tx_if.slave tx_if,
  input  logic         PS2C,
  input  logic         PS2D,
  output logic         ps2c_oe,
  output logic         ps2d_oe
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INHIBIT  = 3'd1,
    S_REQ      = 3'd2,
    S_XFER     = 3'd3,
    S_ACK      = 3'd4,
    S_WAITIDLE = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  localparam logic [11:0] INHIBIT_LAST = 12'd2499;
  localparam logic [11:0] REQ_LAST     = 12'd24;
  localparam logic [3:0]  BIT_STOP     = 4'd9;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [11:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_bit, w_bit_nxt;
  logic [8:0]  r_frame, w_frame_nxt;
  logic        r_ps2c_oe, w_ps2c_oe_nxt;
  logic        r_ps2d_oe, w_ps2d_oe_nxt;
  logic        r_tx_ready, w_tx_ready_nxt;
  logic        r_tx_done, w_tx_done_nxt;
  logic        r_tx_err, w_tx_err_nxt;

  logic [7:0]  r_c_shift, r_d_shift;
  logic [7:0]  w_c_shift_nxt, w_d_shift_nxt;
  logic        r_c_filt, r_d_filt, r_c_filt_d;
  logic        w_fe;
  logic        w_timeout;

  assign w_c_shift_nxt = {r_c_shift[6:0], PS2C};
  assign w_d_shift_nxt = {r_d_shift[6:0], PS2D};
  assign w_fe          = r_c_filt_d & ~r_c_filt;

  // Glitch filter: a line level is only believed after 8 identical samples.
  always_ff @(posedge clk25) begin
    if (!clr) begin
      r_c_shift  <= 8'hFF;
      r_d_shift  <= 8'hFF;
      r_c_filt   <= 1'b1;
      r_d_filt   <= 1'b1;
      r_c_filt_d <= 1'b1;
    end else begin
      r_c_shift  <= w_c_shift_nxt;
      r_d_shift  <= w_d_shift_nxt;
      r_c_filt_d <= r_c_filt;
      if (w_c_shift_nxt == 8'hFF)      r_c_filt <= 1'b1;
      else if (w_c_shift_nxt == 8'h00) r_c_filt <= 1'b0;
      else                             r_c_filt <= r_c_filt;
      if (w_d_shift_nxt == 8'hFF)      r_d_filt <= 1'b1;
      else if (w_d_shift_nxt == 8'h00) r_d_filt <= 1'b0;
      else                             r_d_filt <= r_d_filt;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [18:0] WDOG_LAST = 19'd374999;
  logic [18:0] r_wdog;
  logic        w_wdog_run;

  assign w_wdog_run = (r_state == S_XFER) || (r_state == S_ACK) || (r_state == S_WAITIDLE);
  assign w_timeout  = w_wdog_run && (r_wdog == WDOG_LAST);

  // Watchdog restarts on XFER entry and on every device clock edge.
  always_ff @(posedge clk25) begin
    if (!clr) begin
      r_wdog <= 19'd0;
    end else if ((w_state_nxt == S_XFER && r_state != S_XFER) || w_fe || !w_wdog_run) begin
      r_wdog <= 19'd0;
    end else begin
      r_wdog <= r_wdog + 19'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk25) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_cnt      <= 12'd0;
      r_bit      <= 4'd0;
      r_frame    <= 9'd0;
      r_ps2c_oe  <= 1'b0;
      r_ps2d_oe  <= 1'b0;
      r_tx_ready <= 1'b1;
      r_tx_done  <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_frame    <= w_frame_nxt;
      r_ps2c_oe  <= w_ps2c_oe_nxt;
      r_ps2d_oe  <= w_ps2d_oe_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_tx_done  <= w_tx_done_nxt;
      r_tx_err   <= w_tx_err_nxt;
    end
  end

  // Next state; outputs are computed for the state being entered.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_nxt      = r_bit;
    w_frame_nxt    = r_frame;
    w_ps2c_oe_nxt  = 1'b0;
    w_ps2d_oe_nxt  = r_ps2d_oe;
    w_tx_ready_nxt = 1'b0;
    w_tx_done_nxt  = 1'b0;
    w_tx_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ps2d_oe_nxt = 1'b0;
        if (tx_if.tx_valid) begin
          w_frame_nxt   = {odd_parity(tx_if.tx_data), tx_if.tx_data};
          w_state_nxt   = S_INHIBIT;
          w_cnt_nxt     = 12'd0;
          w_ps2c_oe_nxt = 1'b1;
        end else begin
          w_tx_ready_nxt = 1'b1;
        end
      end
      S_INHIBIT: begin
        w_ps2c_oe_nxt = 1'b1;
        w_ps2d_oe_nxt = 1'b0;
        if (r_cnt == INHIBIT_LAST) begin
          w_state_nxt   = S_REQ;
          w_cnt_nxt     = 12'd0;
          w_ps2d_oe_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 12'd1;
        end
      end
      S_REQ: begin
        w_ps2c_oe_nxt = 1'b1;
        w_ps2d_oe_nxt = 1'b1;
        if (r_cnt == REQ_LAST) begin
          w_state_nxt   = S_XFER;
          w_cnt_nxt     = 12'd0;
          w_bit_nxt     = 4'd0;
          w_ps2c_oe_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 12'd1;
        end
      end
      S_XFER: begin
        // Edge k presents frame bit k-1 (data LSB first, then parity); edge 10 is the stop bit.
        if (w_fe) begin
          if (r_bit == BIT_STOP) begin
            w_ps2d_oe_nxt = 1'b0;
            w_state_nxt   = S_ACK;
            w_bit_nxt     = 4'd0;
          end else begin
            w_ps2d_oe_nxt = ~r_frame[r_bit];
            w_bit_nxt     = r_bit + 4'd1;
          end
        end else if (w_timeout) begin
          w_state_nxt   = S_ERR;
          w_ps2d_oe_nxt = 1'b0;
          w_tx_err_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_XFER;
        end
      end
      S_ACK: begin
        w_ps2d_oe_nxt = 1'b0;
        if (w_fe) begin
          if (!r_d_filt) begin
            w_state_nxt = S_WAITIDLE;
          end else begin
            w_state_nxt  = S_ERR;
            w_tx_err_nxt = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt  = S_ERR;
          w_tx_err_nxt = 1'b1;
        end else begin
          w_state_nxt = S_ACK;
        end
      end
      S_WAITIDLE: begin
        w_ps2d_oe_nxt = 1'b0;
        if (r_c_filt && r_d_filt) begin
          w_state_nxt   = S_DONE;
          w_tx_done_nxt = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt  = S_ERR;
          w_tx_err_nxt = 1'b1;
        end else begin
          w_state_nxt = S_WAITIDLE;
        end
      end
      S_DONE, S_ERR: begin
        w_ps2d_oe_nxt  = 1'b0;
        w_state_nxt    = S_IDLE;
        w_tx_ready_nxt = 1'b1;
      end
      default: begin
        w_ps2d_oe_nxt  = 1'b0;
        w_state_nxt    = S_IDLE;
        w_tx_ready_nxt = 1'b1;
      end
    endcase
  end

  assign ps2c_oe        = r_ps2c_oe;
  assign ps2d_oe        = r_ps2d_oe;
  assign tx_if.tx_ready = r_tx_ready;
  assign tx_if.tx_done  = r_tx_done;
  assign tx_if.tx_err   = r_tx_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model and a frame scoreboard.
module tb_ps2_host_tx;
  logic clk25 = 1'b0;
  logic clr;
  logic PS2C, PS2D;
  logic ps2c_oe, ps2d_oe;
  logic dev_clk, dev_data;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [9:0] exp_q[$];

  ps2_host_tx_if tx_if();

  ps2_host_tx dut (
    .clk25  (clk25),
    .clr    (clr),
    .tx_if  (tx_if.slave),
    .PS2C   (PS2C),
    .PS2D   (PS2D),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe)
  );

  always #20 clk25 = ~clk25;

  // Wired-AND bus with pull-ups: either side may pull a line low.
  assign PS2C = ~ps2c_oe & dev_clk;
  assign PS2D = ~ps2d_oe & dev_data;

  always @(negedge clk25) begin
    if (tx_if.tx_done === 1'b1) done_cnt++;
    if (tx_if.tx_err === 1'b1) err_cnt++;
    if (tx_if.tx_done === 1'b1 && tx_if.tx_err === 1'b1) both_cnt++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk25);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected device view of a frame: data LSB first, odd parity, stop bit 1.
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic send_req(input logic [7:0] d, input bit push);
    int t = 0;
    while (tx_if.tx_ready !== 1'b1 && t < 1000) begin
      tick(1);
      t++;
    end
    check("ready_before_req", 32'(tx_if.tx_ready), 32'd1);
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    tick(1);
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = ~d;
    if (push) exp_q.push_back(exp_frame(d));
  endtask

  // Device: waits for request-to-send, then clocks nedges edges; edge 11 carries the ACK.
  task automatic dev_run(input int half, input int nedges, input bit ack_low,
                         output logic [9:0] cap, output int c_hold);
    int t = 0;
    cap = 10'd0;
    c_hold = 0;
    while (!(ps2c_oe === 1'b0 && ps2d_oe === 1'b1) && t < 4000) begin
      if (ps2c_oe === 1'b1) c_hold++;
      tick(1);
      t++;
    end
    check("start_seen", 32'(t < 4000), 32'd1);
    if (t < 4000) begin
      for (int k = 1; k <= nedges; k++) begin
        if (k == 11) dev_data = ~ack_low;
        tick(half);
        dev_clk = 1'b0;
        tick(half);
        dev_clk = 1'b1;
        if (k <= 10) cap[k-1] = PS2D;
      end
      dev_data = 1'b1;
    end
  endtask

  task automatic sb_compare(input logic [9:0] cap);
    logic [9:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("frame_bits", 32'(cap), 32'(e));
    end else begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end
  endtask

  task automatic finish_frame(input logic [9:0] cap, input int hold, input bit ack_low,
                              input int d0, input int e0);
    int t = 0;
    check("inhibit_len", 32'(hold), 32'd2525);
    sb_compare(cap);
    while (done_cnt == d0 && err_cnt == e0 && t < 2000) begin
      tick(1);
      t++;
    end
    tick(2);
    check("done_pulses", 32'(done_cnt - d0), ack_low ? 32'd1 : 32'd0);
    check("err_pulses", 32'(err_cnt - e0), ack_low ? 32'd0 : 32'd1);
    check("ready_after", 32'(tx_if.tx_ready), 32'd1);
    check("oe_released", 32'({ps2c_oe, ps2d_oe}), 32'd0);
  endtask

  task automatic full_frame(input logic [7:0] d, input int half, input bit ack_low);
    int d0, e0, hold;
    logic [9:0] cap;
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(d, 1'b1);
    dev_run(half, 11, ack_low, cap, hold);
    finish_frame(cap, hold, ack_low, d0, e0);
  endtask

  initial begin
    int d0, e0, hold, ccount;
    logic [9:0] cap;
    clr = 1'b0;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data = 8'h00;
    tick(3);
    check("rst_c_oe", 32'(ps2c_oe), 32'd0);
    check("rst_d_oe", 32'(ps2d_oe), 32'd0);
    check("rst_ready", 32'(tx_if.tx_ready), 32'd1);
    check("rst_done", 32'(tx_if.tx_done), 32'd0);
    check("rst_err", 32'(tx_if.tx_err), 32'd0);
    clr = 1'b1;
    tick(10);

    // 0xED at 12.5 kHz device clock, ACKed.
    full_frame(8'hED, 1000, 1'b1);
    full_frame(8'hF4, 150, 1'b1);
    full_frame(8'h00, 150, 1'b1);
    // Device NACKs by leaving data high.
    full_frame(8'hAB, 150, 1'b0);

    // Reset after the fourth device clock edge.
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'hED, 1'b0);
    dev_run(150, 4, 1'b1, cap, hold);
    clr = 1'b0;
    tick(1);
    check("mid_rst_c_oe", 32'(ps2c_oe), 32'd0);
    check("mid_rst_d_oe", 32'(ps2d_oe), 32'd0);
    check("mid_rst_ready", 32'(tx_if.tx_ready), 32'd1);
    clr = 1'b1;
    tick(200);
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_rst_no_err", 32'(err_cnt - e0), 32'd0);
    full_frame(8'hED, 150, 1'b1);

    // Second request mid-frame is ignored; frame data is already latched.
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'hED, 1'b1);
    fork
      dev_run(150, 11, 1'b1, cap, hold);
      begin
        tick(3000);
        check("ready_low_mid", 32'(tx_if.tx_ready), 32'd0);
        tx_if.tx_data = 8'h55;
        tx_if.tx_valid = 1'b1;
        tick(1);
        tx_if.tx_valid = 1'b0;
      end
    join
    finish_frame(cap, hold, 1'b1, d0, e0);
    ccount = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ps2c_oe === 1'b1) ccount++;
      tick(1);
    end
    check("no_second_frame", 32'(ccount), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // Device never clocks: default build waits in XFER indefinitely.
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'h3C, 1'b0);
    dev_run(150, 0, 1'b1, cap, hold);
    tick(5000);
    check("hang_no_err", 32'(err_cnt - e0), 32'd0);
    check("hang_no_done", 32'(done_cnt - d0), 32'd0);
    check("hang_not_ready", 32'(tx_if.tx_ready), 32'd0);
    check("hang_start_held", 32'({ps2c_oe, ps2d_oe}), 32'd1);
    clr = 1'b0;
    tick(2);
    clr = 1'b1;
    tick(2);
    check("hang_rst_ready", 32'(tx_if.tx_ready), 32'd1);

    check("no_done_err_overlap", 32'(both_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have port clk25  input  1  25 MHz system clock; all logic on rising edge.
REQ-002 SHALL have port clr  input  1  synchronous, active-low reset.
REQ-003 SHALL have port tx_data  input  8  command byte to send to the keyboard.
REQ-004 SHALL have port tx_valid  input  1  send request; accepted only while tx_ready=1.
REQ-005 SHALL have port PS2C  input  1  raw PS/2 clock line level.
REQ-006 SHALL have port PS2D  input  1  raw PS/2 data line level.
REQ-007 SHALL have port ps2c_oe  output  1  1 = pull clock line low; 0 = release to high-Z at top level.
REQ-008 SHALL have port ps2d_oe  output  1  1 = pull data line low; 0 = release to high-Z at top level.
REQ-009 SHALL have port tx_ready  output  1  high only in IDLE.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse on acknowledged completion.
REQ-011 SHALL have port tx_err  output  1  one-cycle pulse on NACK or timeout.

Function
REQ-012 SHALL filter PS2C and PS2D with 8-sample shift registers; filtered bit becomes 1 after 8 consecutive 1 samples, 0 after 8 consecutive 0 samples, else holds.
REQ-013 SHALL detect a device clock falling edge as filtered PS2C going 1->0 (one-cycle strobe fe).
REQ-014 SHALL implement states IDLE, INHIBIT, REQ, XFER, ACK, WAITIDLE, DONE, ERR.
REQ-015 IDLE: ps2c_oe=0, ps2d_oe=0, tx_ready=1; tx_valid=1 latches tx_data, computes odd parity (parity = ~^tx_data), goes to INHIBIT.
REQ-016 INHIBIT: ps2c_oe=1, ps2d_oe=0 for exactly 2500 cycles (100 us), then REQ.
REQ-017 REQ: ps2c_oe=1, ps2d_oe=1 (start bit) for exactly 25 cycles, then XFER with ps2c_oe=0, ps2d_oe held 1, bit index 0.
REQ-018 XFER: on fe number k (k=1..8) SHALL present data bit k-1 (LSB first, ps2d_oe = ~bit); on fe 9 present parity; on fe 10 release data (stop bit, ps2d_oe=0) and enter ACK.
REQ-019 ACK: on next fe, filtered PS2D=0 -> WAITIDLE; filtered PS2D=1 -> ERR.
REQ-020 WAITIDLE: when filtered PS2C=1 and filtered PS2D=1 -> DONE.
REQ-021 DONE: tx_done=1 for one cycle, then IDLE; ERR: tx_err=1 for one cycle, both oe=0, then IDLE.
REQ-022 tx_valid while tx_ready=0 SHALL be ignored; tx_data changes after acceptance SHALL not affect the frame.
REQ-023 tx_done and tx_err SHALL never be asserted in the same cycle.
REQ-024 ps2c_oe SHALL be 0 in every state except INHIBIT and REQ.

Reset
REQ-025 clr=0 at a rising edge SHALL force IDLE, ps2c_oe=0, ps2d_oe=0, tx_ready=1, tx_done=0, tx_err=0, bit index 0, counters 0, filter registers all-ones, filtered lines 1.
REQ-026 Reset mid-frame SHALL release both lines by the following cycle and produce no tx_done/tx_err pulse.

Configuration
REQ-027 Macro PS2_TX_TIMEOUT_EN defined: 19-bit watchdog cleared on entry to XFER and on every fe; reaching 375000 cycles (15 ms) in XFER, ACK or WAITIDLE SHALL enter ERR.
REQ-028 Macro PS2_TX_TIMEOUT_EN undefined: no watchdog; those states wait indefinitely.

Verification
REQ-029 tx_data=0xED, device model clocks 11 edges at 12.5 kHz, ACK low -> bits sampled 1,0,1,1,0,1,1,1, parity 1, stop 1, one tx_done pulse.
REQ-030 tx_data=0xF4 -> parity 0; tx_data=0x00 -> parity 1; ps2c_oe low-time exactly 2525 cycles before release.
REQ-031 Device leaves PS2D high at ACK edge -> one tx_err pulse, no tx_done, return to IDLE.
REQ-032 With PS2_TX_TIMEOUT_EN, device never clocks -> tx_err exactly 375000 cycles after entering XFER; without it, state stays XFER.
REQ-033 clr=0 after 4th fe of a frame -> both oe=0 next cycle, tx_ready=1, no pulses; next 0xED frame completes normally.
REQ-034 tx_valid pulsed with 0x55 mid-frame of 0xED -> ignored; only 0xED transmitted.
